// File: rtl/pwm_ctrl_pkg.sv
// pwm_ctrl_pkg: shared definitions for the PWM controller.
//   - register byte offsets within the 256-byte block
//   - bus handshake state encoding
//   - NCH_MAX, the largest supported channel count
//   - apply_wstrb(): byte-lane merge of a bus write into a 32-bit register
package pwm_ctrl_pkg;

    localparam int NCH_MAX = 8;

    localparam logic [7:0] CTRL        = 8'h00;
    localparam logic [7:0] STATUS      = 8'h08;
    localparam logic [7:0] PERIOD_BASE = 8'h10;
    localparam logic [7:0] DUTY_BASE   = 8'h40;
    localparam logic [7:0] STEP_BASE   = 8'h60;
    localparam logic [7:0] ACT_BASE    = 8'h80;

    typedef enum logic {
        BUS_IDLE = 1'b0,
        BUS_ACK  = 1'b1
    } bus_state_t;

    function automatic logic [31:0] apply_wstrb(input logic [31:0] cur,
                                                 input logic [31:0] wdata,
                                                 input logic [3:0]  wstrb);
        logic [31:0] res;
        res = cur;
        for (int b = 0; b < 4; b++) begin
            if (wstrb[b]) res[8*b +: 8] = wdata[8*b +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/pwm_ctrl_chan.sv
// pwm_ctrl_chan: one PWM channel's register set.
// Holds the shadow PERIOD/DUTY (and STEP when PWM_FADE_EN is defined), the
// active period/duty seen by the counter unit, and the pending flag. Shadow
// values move to the active registers only on a period boundary (co=1).
//
// Optional feature macro: PWM_FADE_EN -- ramps active duty toward DUTY by
// STEP per boundary; without it STEP reads 0 and DUTY is copied directly.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   wdata, wstrb        bus write data and byte enables
//   wr_period/duty/step one-cycle write strobes for this channel's registers
//   co                  period-boundary pulse from the counter unit
//   en_nxt              channel enable as it will be after this edge
//   period, duty, step  shadow register read-back
//   act_duty            active duty read-back
//   pending             shadow differs from active, commit outstanding
//   pwm_max, pwm_data   registered outputs to the counter unit
module pwm_ctrl_chan
    import pwm_ctrl_pkg::*;
#(
    parameter logic [31:0] DEFAULT_MAX = 32'd999
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic        wr_period,
    input  logic        wr_duty,
    input  logic        wr_step,
    input  logic        co,
    input  logic        en_nxt,
    output logic [31:0] period,
    output logic [31:0] duty,
    output logic [31:0] step,
    output logic [31:0] act_duty,
    output logic        pending,
    output logic [31:0] pwm_max,
    output logic [31:0] pwm_data
);

    logic        commit;
    logic [31:0] duty_commit;
    logic [31:0] act_duty_nxt;

    assign commit       = co && pending;
    assign act_duty_nxt = commit ? duty_commit : act_duty;

`ifdef PWM_FADE_EN
    // One fade step toward tgt, saturating at tgt; 33-bit so nothing wraps.
    function automatic logic [31:0] fade_duty(input logic [31:0] cur,
                                              input logic [31:0] tgt,
                                              input logic [31:0] stp);
        logic [32:0] up;
        logic [32:0] gap;
        up  = {1'b0, cur} + {1'b0, stp};
        gap = {1'b0, cur} - {1'b0, tgt};
        if (stp == 32'd0 || cur == tgt) return tgt;
        if (cur < tgt) return (up >= {1'b0, tgt}) ? tgt : up[31:0];
        return ({1'b0, stp} >= gap) ? tgt : (cur - stp);
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step <= '0;
        end else if (wr_step) begin
            step <= apply_wstrb(step, wdata, wstrb);
        end
    end

    assign duty_commit = fade_duty(act_duty, duty, step);
`else
    logic unused_step;
    assign unused_step = wr_step;
    assign step        = '0;
    assign duty_commit = duty;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            period   <= DEFAULT_MAX;
            duty     <= '0;
            pwm_max  <= DEFAULT_MAX;
            act_duty <= '0;
            pending  <= 1'b0;
            pwm_data <= '0;
        end else begin
            if (wr_period) period <= apply_wstrb(period, wdata, wstrb);
            if (wr_duty)   duty   <= apply_wstrb(duty, wdata, wstrb);
            // Nonblocking reads of period/duty give the pre-write shadow
            // when a write and a boundary share an edge.
            if (commit) begin
                pwm_max  <= period;
                act_duty <= duty_commit;
            end
            // A write always re-arms pending; otherwise a commit clears it
            // once the active duty has reached its target (period always
            // matches straight after a commit).
            if (wr_period || wr_duty) pending <= 1'b1;
            else if (commit)          pending <= (duty_commit != duty);
            pwm_data <= en_nxt ? act_duty_nxt : 32'd0;
        end
    end

endmodule

// File: rtl/pwm_ctrl.sv
// pwm_ctrl: picomem-bus register block for a bank of NCH PWM counter units.
// Single-cycle handshake (IDLE -> ACK -> IDLE); writes land on the edge that
// raises mem_ready, read data is registered alongside it. Each channel's
// shadow registers commit to the counter outputs at that channel's boundary.
//
// Optional feature macro: PWM_FADE_EN (see pwm_ctrl_chan).
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   mem_valid/mem_ready    bus request / one-cycle acknowledge
//   mem_addr               byte address, bits [7:2] decoded
//   mem_wdata, mem_wstrb   write data, byte enables (0 = read)
//   mem_rdata              read data, valid while mem_ready=1
//   pwm_max, pwm_data      per-channel active period / gated duty (NCH x 32)
//   pwm_co                 per-channel period-boundary pulse
module pwm_ctrl
    import pwm_ctrl_pkg::*;
#(
    parameter int          NCH         = 4,
    parameter logic [31:0] DEFAULT_MAX = 32'd999
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mem_valid,
    output logic              mem_ready,
    input  logic [31:0]       mem_addr,
    input  logic [31:0]       mem_wdata,
    input  logic [3:0]        mem_wstrb,
    output logic [31:0]       mem_rdata,
    output logic [NCH*32-1:0] pwm_max,
    output logic [NCH*32-1:0] pwm_data,
    input  logic [NCH-1:0]    pwm_co
);

    if (NCH < 1 || NCH > NCH_MAX) begin : g_bad_nch
        $error("pwm_ctrl: NCH must be 1..%0d", NCH_MAX);
    end

    bus_state_t     state;
    logic [7:0]     off;
    logic           req;
    logic           wr;
    logic           unused_addr;
    logic [NCH-1:0] ctrl;
    logic [NCH-1:0] ctrl_nxt;
    logic [31:0]    ctrl_wr;
    logic [NCH-1:0] pending;
    logic [NCH-1:0] wr_period;
    logic [NCH-1:0] wr_duty;
    logic [NCH-1:0] wr_step;
    logic [31:0]    period   [NCH];
    logic [31:0]    duty     [NCH];
    logic [31:0]    step     [NCH];
    logic [31:0]    act_duty [NCH];
    logic [31:0]    rdata_nxt;

    assign off         = {mem_addr[7:2], 2'b00};
    assign unused_addr = ^{mem_addr[31:8], mem_addr[1:0]};
    assign req         = (state == BUS_IDLE) && mem_valid;
    assign wr          = req && (mem_wstrb != 4'b0000);
    assign ctrl_wr     = apply_wstrb(32'(ctrl), mem_wdata, mem_wstrb);

    // ctrl_nxt feeds the channels so an enable change reaches pwm_data on
    // the same edge the CTRL write lands.
    always_comb begin
        ctrl_nxt = ctrl;
        if (wr && off == CTRL) ctrl_nxt = ctrl_wr[NCH-1:0];
    end

    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            wr_period[i] = wr && (off == PERIOD_BASE + 8'(4*i));
            wr_duty[i]   = wr && (off == DUTY_BASE   + 8'(4*i));
            wr_step[i]   = wr && (off == STEP_BASE   + 8'(4*i));
        end
    end

    always_comb begin
        rdata_nxt = '0;
        if (off == CTRL)   rdata_nxt = 32'(ctrl);
        if (off == STATUS) rdata_nxt = 32'(pending);
        for (int i = 0; i < NCH; i++) begin
            if (off == PERIOD_BASE + 8'(4*i)) rdata_nxt = period[i];
            if (off == DUTY_BASE   + 8'(4*i)) rdata_nxt = duty[i];
            if (off == STEP_BASE   + 8'(4*i)) rdata_nxt = step[i];
            if (off == ACT_BASE    + 8'(4*i)) rdata_nxt = act_duty[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= BUS_IDLE;
            mem_ready <= 1'b0;
            mem_rdata <= '0;
            ctrl      <= '0;
        end else begin
            ctrl <= ctrl_nxt;
            case (state)
                BUS_IDLE: begin
                    if (mem_valid) begin
                        state     <= BUS_ACK;
                        mem_ready <= 1'b1;
                        mem_rdata <= rdata_nxt;
                    end
                end
                BUS_ACK: begin
                    state     <= BUS_IDLE;
                    mem_ready <= 1'b0;
                    mem_rdata <= '0;
                end
                default: begin
                    state     <= BUS_IDLE;
                    mem_ready <= 1'b0;
                    mem_rdata <= '0;
                end
            endcase
        end
    end

    for (genvar g = 0; g < NCH; g++) begin : g_chan
        pwm_ctrl_chan #(
            .DEFAULT_MAX(DEFAULT_MAX)
        ) u_chan (
            .clk      (clk),
            .rst_n    (rst_n),
            .wdata    (mem_wdata),
            .wstrb    (mem_wstrb),
            .wr_period(wr_period[g]),
            .wr_duty  (wr_duty[g]),
            .wr_step  (wr_step[g]),
            .co       (pwm_co[g]),
            .en_nxt   (ctrl_nxt[g]),
            .period   (period[g]),
            .duty     (duty[g]),
            .step     (step[g]),
            .act_duty (act_duty[g]),
            .pending  (pending[g]),
            .pwm_max  (pwm_max[g*32 +: 32]),
            .pwm_data (pwm_data[g*32 +: 32])
        );
    end

endmodule

// File: tb/tb_pwm_ctrl.sv
// tb_pwm_ctrl: scoreboard bench for pwm_ctrl. Bus reads push their expected
// data (from a register-map level model) into a queue; a monitor pops and
// compares whenever mem_ready is seen. PWM outputs are compared against the
// model after every operation. Build with +define+PWM_FADE_EN for the fade
// variant.
`timescale 1ns/1ps
module tb_pwm_ctrl;

    localparam int          NCH     = 4;
    localparam logic [31:0] DEF_MAX = 32'd999;
`ifdef PWM_FADE_EN
    localparam bit FADE = 1'b1;
`else
    localparam bit FADE = 1'b0;
`endif

    logic              clk       = 1'b0;
    logic              rst_n     = 1'b0;
    logic              mem_valid = 1'b0;
    logic              mem_ready;
    logic [31:0]       mem_addr  = '0;
    logic [31:0]       mem_wdata = '0;
    logic [3:0]        mem_wstrb = '0;
    logic [31:0]       mem_rdata;
    logic [NCH*32-1:0] pwm_max;
    logic [NCH*32-1:0] pwm_data;
    logic [NCH-1:0]    pwm_co    = '0;

    always #5 clk = ~clk;

    pwm_ctrl #(.NCH(NCH), .DEFAULT_MAX(DEF_MAX)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .mem_valid(mem_valid),
        .mem_ready(mem_ready),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb),
        .mem_rdata(mem_rdata),
        .pwm_max  (pwm_max),
        .pwm_data (pwm_data),
        .pwm_co   (pwm_co)
    );

    int n_checks = 0;
    int n_fail   = 0;

    function automatic void chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
        end
    endfunction

    // ---------------- reference model ----------------
    logic [31:0]    m_period [NCH];
    logic [31:0]    m_duty   [NCH];
    logic [31:0]    m_step   [NCH];
    logic [31:0]    m_amax   [NCH];
    logic [31:0]    m_aduty  [NCH];
    bit             m_pend   [NCH];
    logic [NCH-1:0] m_ctrl;

    function automatic void model_reset();
        for (int c = 0; c < NCH; c++) begin
            m_period[c] = DEF_MAX; m_amax[c] = DEF_MAX;
            m_duty[c] = 0; m_step[c] = 0; m_aduty[c] = 0; m_pend[c] = 0;
        end
        m_ctrl = '0;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    function automatic void model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        int          o;
        logic [31:0] t;
        o = int'(a[7:0]) & 'hFC;
        if (o == 0) begin
            t = merge(32'(m_ctrl), d, s);
            m_ctrl = t[NCH-1:0];
        end
        for (int c = 0; c < NCH; c++) begin
            if (o == 'h10 + 4*c) begin m_period[c] = merge(m_period[c], d, s); m_pend[c] = 1; end
            if (o == 'h40 + 4*c) begin m_duty[c]   = merge(m_duty[c], d, s);   m_pend[c] = 1; end
            if (o == 'h60 + 4*c) m_step[c] = merge(m_step[c], d, s);
        end
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a);
        int          o;
        logic [31:0] st;
        o  = int'(a[7:0]) & 'hFC;
        st = 0;
        for (int c = 0; c < NCH; c++) st[c] = m_pend[c];
        if (o == 0) return 32'(m_ctrl);
        if (o == 8) return st;
        for (int c = 0; c < NCH; c++) begin
            if (o == 'h10 + 4*c) return m_period[c];
            if (o == 'h40 + 4*c) return m_duty[c];
            if (o == 'h60 + 4*c) return FADE ? m_step[c] : 32'd0;
            if (o == 'h80 + 4*c) return m_aduty[c];
        end
        return 0;
    endfunction

    // Boundary for channel c: copy period, move duty toward target.
    function automatic void model_commit(input int c);
        longint cur, tgt, stp;
        if (!m_pend[c]) return;
        m_amax[c] = m_period[c];
        cur = longint'(m_aduty[c]);
        tgt = longint'(m_duty[c]);
        stp = FADE ? longint'(m_step[c]) : 0;
        if (stp == 0)        cur = tgt;
        else if (cur < tgt)  cur = (cur + stp > tgt) ? tgt : cur + stp;
        else if (cur > tgt)  cur = (cur - stp < tgt) ? tgt : cur - stp;
        m_aduty[c] = 32'(cur);
        m_pend[c]  = (m_aduty[c] != m_duty[c]);
    endfunction

    // ---------------- scoreboard + monitor ----------------
    typedef struct {
        bit          is_read;
        logic [31:0] exp;
        string       name;
    } sb_t;
    sb_t  sb_q[$];
    sb_t  mon_e;
    logic prev_ready = 1'b0;

    always @(negedge clk) begin
        if (mem_ready === 1'b1) begin
            chk("ready_single_cycle", 32'(prev_ready), 32'd0);
            chk("sb_has_entry", 32'(sb_q.size() != 0), 32'd1);
            if (sb_q.size() != 0) begin
                mon_e = sb_q.pop_front();
                if (mon_e.is_read) chk(mon_e.name, mem_rdata, mon_e.exp);
            end
        end
        prev_ready <= mem_ready;
    end

    // ---------------- stimulus tasks ----------------
    task automatic bus_xfer(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input logic [NCH-1:0] co_mask, input bit use_exp,
                            input logic [31:0] exp, input string name);
        sb_t e;
        int  cyc;
        @(negedge clk);
        e.is_read = (strb == 4'b0000);
        e.exp     = use_exp ? exp : model_read(addr);
        e.name    = name;
        sb_q.push_back(e);
        mem_addr = addr; mem_wdata = data; mem_wstrb = strb; mem_valid = 1'b1;
        pwm_co   = co_mask;
        @(negedge clk);
        cyc    = 1;
        pwm_co = '0;
        while (mem_ready !== 1'b1 && cyc < 16) begin
            @(negedge clk);
            cyc++;
        end
        chk({name, "_latency"}, 32'(cyc), 32'd1);
        mem_valid = 1'b0; mem_wstrb = '0;
        for (int c = 0; c < NCH; c++) if (co_mask[c]) model_commit(c);
        if (strb != 4'b0000) model_write(addr, data, strb);
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data);
        bus_xfer(addr, data, 4'hF, '0, 1'b0, 32'd0, "wr");
    endtask

    task automatic rd(input logic [31:0] addr, input logic [31:0] exp, input string name);
        bus_xfer(addr, 32'd0, 4'h0, '0, 1'b1, exp, name);
    endtask

    task automatic pulse_co(input logic [NCH-1:0] mask);
        @(negedge clk);
        pwm_co = mask;
        @(negedge clk);
        pwm_co = '0;
        for (int c = 0; c < NCH; c++) if (mask[c]) model_commit(c);
    endtask

    task automatic check_outputs(input string tag);
        for (int c = 0; c < NCH; c++) begin
            chk($sformatf("%s_pwm_max%0d", tag, c), pwm_max[c*32 +: 32], m_amax[c]);
            chk($sformatf("%s_pwm_data%0d", tag, c), pwm_data[c*32 +: 32],
                m_ctrl[c] ? m_aduty[c] : 32'd0);
        end
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        logic [7:0]  o;
        case ($urandom_range(0, 6))
            0:       o = 8'h00;
            1:       o = 8'h08;
            2:       o = 8'h10 + 8'(4 * $urandom_range(0, 7));
            3:       o = 8'h40 + 8'(4 * $urandom_range(0, 7));
            4:       o = 8'h60 + 8'(4 * $urandom_range(0, 7));
            5:       o = 8'h80 + 8'(4 * $urandom_range(0, 7));
            default: o = 8'($urandom_range(0, 255));
        endcase
        a      = $urandom();
        a[7:0] = o;
        a[1:0] = 2'($urandom_range(0, 3));
        return a;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- test sequence ----------------
    initial begin
        logic [31:0]    a, d;
        logic [3:0]     s;
        logic [NCH-1:0] m;
        int             drain;

        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_mem_ready", 32'(mem_ready), 32'd0);
        chk("rst_mem_rdata", mem_rdata, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_pwm_max0", pwm_max[31:0], 32'd999);
        chk("rst_pwm_data0", pwm_data[31:0], 32'd0);
        check_outputs("rst");
        rd(32'h10, 32'd999, "rst_period0");
        rd(32'h40, 32'd0,   "rst_duty0");
        rd(32'h08, 32'd0,   "rst_status");

        // Deferred commit of DUTY[0]
        wr(32'h00, 32'd1);
        wr(32'h40, 32'd300);
        rd(32'h08, 32'd1, "status_pending");
        chk("duty0_before_boundary", pwm_data[31:0], 32'd0);
        pulse_co(4'b0001);
        chk("duty0_after_boundary", pwm_data[31:0], 32'd300);
        rd(32'h08, 32'd0, "status_cleared");
        check_outputs("commit0");

        // Write colliding with a boundary commits the old shadow
        wr(32'h44, 32'd200);
        bus_xfer(32'h44, 32'd500, 4'hF, 4'b0010, 1'b0, 32'd0, "wr_collide");
        rd(32'h84, 32'd200, "act1_collide");
        rd(32'h08, 32'd2,   "status1_collide");
        pulse_co(4'b0010);
        rd(32'h84, 32'd500, "act1_next_boundary");
        rd(32'h08, 32'd0,   "status1_cleared");

        // Byte strobes and unmapped offset
        bus_xfer(32'h48, 32'hAABBCCDD, 4'b0001, '0, 1'b0, 32'd0, "wr_byte");
        rd(32'h48, 32'h000000DD, "duty2_byte");
        rd(32'hFC, 32'd0, "unmapped_fc");
        pulse_co(4'b0100);
        check_outputs("byte");

`ifdef PWM_FADE_EN
        wr(32'h6C, 32'd100);
        wr(32'h4C, 32'd250);
        pulse_co(4'b1000);
        rd(32'h8C, 32'd100, "fade_up1");
        rd(32'h08, 32'd8,   "fade_status_up1");
        pulse_co(4'b1000);
        rd(32'h8C, 32'd200, "fade_up2");
        pulse_co(4'b1000);
        rd(32'h8C, 32'd250, "fade_up3");
        rd(32'h08, 32'd0,   "fade_status_done");
        wr(32'h4C, 32'd30);
        pulse_co(4'b1000);
        rd(32'h8C, 32'd150, "fade_dn1");
        pulse_co(4'b1000);
        rd(32'h8C, 32'd50,  "fade_dn2");
        rd(32'h08, 32'd8,   "fade_status_dn2");
        pulse_co(4'b1000);
        rd(32'h8C, 32'd30,  "fade_dn3");
        rd(32'h08, 32'd0,   "fade_status_dn_done");
`else
        wr(32'h60, 32'd5);
        rd(32'h60, 32'd0, "step_absent");
`endif

        // CTRL acts immediately
        wr(32'h00, 32'd0);
        chk("ctrl_off_data0", pwm_data[31:0], 32'd0);
        wr(32'h00, 32'd1);
        chk("ctrl_on_data0", pwm_data[31:0], 32'd300);
        check_outputs("ctrl");

        // Reset in the middle of a transaction
        @(negedge clk);
        mem_addr = 32'h40; mem_wdata = 32'd123; mem_wstrb = 4'hF; mem_valid = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_ready_high", 32'(mem_ready), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("abort_ready_drop", 32'(mem_ready), 32'd0);
        mem_valid = 1'b0; mem_wstrb = '0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        check_outputs("abort");
        rd(32'h40, 32'd0, "abort_duty0");
        rd(32'h00, 32'd0, "abort_ctrl");

        // Randomized traffic against the model
        for (int n = 0; n < 250; n++) begin
            a = rand_addr();
            d = ($urandom_range(0, 7) == 0) ? $urandom() : $urandom_range(0, 600);
            s = 4'($urandom_range(0, 15));
            if (s == 4'b0000 && $urandom_range(0, 1) == 1) s = 4'hF;
            m = ($urandom_range(0, 3) == 0) ? NCH'($urandom()) : '0;
            case ($urandom_range(0, 2))
                0:       bus_xfer(a, d, s, m, 1'b0, 32'd0, "rnd_bus");
                1:       pulse_co(NCH'($urandom()));
                default: bus_xfer(a, 32'd0, 4'h0, m, 1'b0, 32'd0, "rnd_rd");
            endcase
            check_outputs("rnd");
        end

        drain = 0;
        while (sb_q.size() != 0 && drain < 20) begin
            @(negedge clk);
            drain++;
        end
        chk("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
